// File: rtl/pipe_mon_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_mon_pkg
//  Description : Shared definitions for the pipeline commit tracker:
//                tracker FSM state encoding and default parameter values.
//  Revision    : 1.0 - initial release
// ============================================================================
package pipe_mon_pkg;

    // Default parameter values for pipe_commit_tracker
    localparam int c_def_num_stages = 4;
    localparam int c_def_cnt_w      = 8;
    localparam int c_def_cnt_limit  = 132;
    localparam int c_def_end_window = 50;

    // Tracker FSM encoding (explicit 2-bit width)
    localparam logic [1:0] c_st_idle    = 2'd0;
    localparam logic [1:0] c_st_start   = 2'd1;
    localparam logic [1:0] c_st_started = 2'd2;

    typedef enum logic [1:0] {
        IDLE    = c_st_idle,
        START   = c_st_start,
        STARTED = c_st_started
    } state_e;

endpackage : pipe_mon_pkg
`default_nettype wire

// File: rtl/pipe_mon_stage.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_mon_stage
//  Description : One token-present bit of the shadow pipeline. Loads i_d
//                when the stage is allowed to advance (i_en), holds when
//                stalled, and is cleared by a flush regardless of i_en.
//  Ports       : clk, rst_n   - clock, asynchronous active-low reset
//                i_flush      - clear the token bit at the next edge
//                i_en         - stage advances this cycle (not stalled)
//                i_d          - token arriving from the upstream stage
//                o_q          - token present in this stage
//  Revision    : 1.0 - initial release
// ============================================================================
module pipe_mon_stage
    import pipe_mon_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic i_flush,
    input  logic i_en,
    input  logic i_d,
    output logic o_q
);

    logic r_tok_q;
    logic w_tok_d;

    // Flush has priority over both advance and hold
    always_comb begin
        w_tok_d = r_tok_q;
        if (i_flush) begin
            w_tok_d = 1'b0;
        end else if (i_en) begin
            w_tok_d = i_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tok_q <= 1'b0;
        end else begin
            r_tok_q <= w_tok_d;
        end
    end

    assign o_q = r_tok_q;

endmodule : pipe_mon_stage
`default_nettype wire

// File: rtl/pipe_commit_tracker.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_commit_tracker
//  Description : Tracks a single token launched on the START cycle through
//                a NUM_STAGES-deep stalled/flushed pipeline, measures the
//                cycles from start to commit and flags first/second
//                in-window commits and window overrun.
//  Ports       : clk, rst_n    - clock, asynchronous active-low reset
//                issue_i       - request to start tracking
//                valid_s1_i    - stage-1 valid from the pipeline
//                stall_i       - per-stage stall, bit k = stage k+1
//                flush_i       - pipeline flush
//                start_o       - one-cycle start pulse
//                started_o     - sticky started flag
//                commit_o      - tracked-token commit pulse
//                ended_o       - sticky first in-window end
//                ended2_o      - sticky second end
//                timeout_o     - sticky window overrun
//                cycle_cnt_o   - cycles since start (saturating)
//                latency_o     - cycle_cnt_o captured at first end
//                tok_o         - token present, stages 2..NUM_STAGES
//  Revision    : 1.0 - initial release
// ============================================================================
module pipe_commit_tracker
    import pipe_mon_pkg::*;
#(
    parameter int NUM_STAGES = c_def_num_stages,
    parameter int CNT_W      = c_def_cnt_w,
    parameter int CNT_LIMIT  = c_def_cnt_limit,
    parameter int END_WINDOW = c_def_end_window
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  issue_i,
    input  logic                  valid_s1_i,
    input  logic [NUM_STAGES-1:0] stall_i,
    input  logic                  flush_i,
    output logic                  start_o,
    output logic                  started_o,
    output logic                  commit_o,
    output logic                  ended_o,
    output logic                  ended2_o,
    output logic                  timeout_o,
    output logic [CNT_W-1:0]      cycle_cnt_o,
    output logic [CNT_W-1:0]      latency_o,
    output logic [NUM_STAGES-2:0] tok_o
);

    localparam logic [CNT_W-1:0] c_cnt_limit  = CNT_W'(CNT_LIMIT);
    localparam logic [CNT_W-1:0] c_end_window = CNT_W'(END_WINDOW);

    // ------------------------------------------------------------------
    // Tracker FSM
    // ------------------------------------------------------------------
    state_e r_state_q;
    state_e w_state_d;

    always_comb begin
        w_state_d = r_state_q;
        case (r_state_q)
            IDLE:    if (issue_i) w_state_d = START;
            START:   w_state_d = STARTED;
            STARTED: w_state_d = STARTED;
            default: w_state_d = IDLE;
        endcase
    end

    logic w_start;
    logic w_started;

    assign w_start   = (r_state_q == START);
    assign w_started = (r_state_q == STARTED);

    // Only a token presented in the START cycle is tracked
    logic w_s1;
    assign w_s1 = w_start & valid_s1_i & ~stall_i[0];

    // ------------------------------------------------------------------
    // Shadow token pipeline: element j holds stage j+2
    // ------------------------------------------------------------------
    logic [NUM_STAGES-2:0] w_tok;
    logic [NUM_STAGES-2:0] w_tok_in;
    logic [NUM_STAGES-2:0] w_tok_en;

    for (genvar j = 0; j < NUM_STAGES - 1; j++) begin : g_stage
        if (j == 0) begin : g_first
            assign w_tok_in[j] = w_s1;
        end else begin : g_rest
            // The upstream stage only hands its token over when it is
            // itself moving; a stalled upstream stage keeps its token.
            assign w_tok_in[j] = w_tok[j-1] & ~stall_i[j];
        end

        assign w_tok_en[j] = ~stall_i[j+1];

        pipe_mon_stage u_stage (
            .clk     (clk),
            .rst_n   (rst_n),
            .i_flush (flush_i),
            .i_en    (w_tok_en[j]),
            .i_d     (w_tok_in[j]),
            .o_q     (w_tok[j])
        );
    end

    // ------------------------------------------------------------------
    // Commit, counter and end/latency tracking
    // ------------------------------------------------------------------
    logic             r_commit_q;
    logic             w_commit_d;
    logic [CNT_W-1:0] r_cnt_q;
    logic [CNT_W-1:0] w_cnt_d;
    logic             r_ended_q;
    logic             w_ended_d;
    logic             r_ended2_q;
    logic             w_ended2_d;
    logic [CNT_W-1:0] r_latency_q;
    logic [CNT_W-1:0] w_latency_d;
    logic             w_end_hit;

    always_comb begin
        // Commit is recomputed every cycle (no hold), so it can only pulse
        w_commit_d = ~flush_i & w_tok[NUM_STAGES-2] & ~stall_i[NUM_STAGES-1];

        w_cnt_d = r_cnt_q;
        if ((w_start | w_started) && (r_cnt_q < c_cnt_limit)) begin
            w_cnt_d = r_cnt_q + CNT_W'(1);
        end

        w_end_hit = r_commit_q & w_started & ~r_ended_q & (r_cnt_q <= c_end_window);

        w_ended_d   = r_ended_q | w_end_hit;
        w_latency_d = w_end_hit ? r_cnt_q : r_latency_q;

        // Uses the pre-edge ended flag, so the commit that produces the
        // first end can never also produce the second one.
        w_ended2_d = r_ended2_q | (r_ended_q & r_commit_q & w_started);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state_q   <= IDLE;
            r_commit_q  <= 1'b0;
            r_cnt_q     <= '0;
            r_ended_q   <= 1'b0;
            r_ended2_q  <= 1'b0;
            r_latency_q <= '0;
        end else begin
            r_state_q   <= w_state_d;
            r_commit_q  <= w_commit_d;
            r_cnt_q     <= w_cnt_d;
            r_ended_q   <= w_ended_d;
            r_ended2_q  <= w_ended2_d;
            r_latency_q <= w_latency_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign start_o     = w_start;
    assign started_o   = w_started;
    assign commit_o    = r_commit_q;
    assign ended_o     = r_ended_q;
    assign ended2_o    = r_ended2_q;
    assign cycle_cnt_o = r_cnt_q;
    assign latency_o   = r_latency_q;
    assign tok_o       = w_tok;

    // Timeout is decoded from registered state. It stays set once raised:
    // the counter never decreases, and ended_o cannot rise after the
    // counter has left the window, so the expression is inherently sticky
    // and can never coexist with ended_o.
    assign timeout_o = w_started & ~r_ended_q & (r_cnt_q > c_end_window);

endmodule : pipe_commit_tracker
`default_nettype wire

// File: tb/tb_pipe_commit_tracker.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pipe_commit_tracker
//  Description : Self-checking bench for pipe_commit_tracker. A token-
//                position reference model predicts every output each cycle
//                under directed and randomized stall/flush/issue traffic,
//                including asynchronous reset in mid-tracking.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_commit_tracker;

    localparam int c_n   = 4;
    localparam int c_w   = 8;
    localparam int c_lim = 132;
    localparam int c_ew  = 50;

    logic             clk;
    logic             rst_n;
    logic             issue_i;
    logic             valid_s1_i;
    logic [c_n-1:0]   stall_i;
    logic             flush_i;
    logic             start_o;
    logic             started_o;
    logic             commit_o;
    logic             ended_o;
    logic             ended2_o;
    logic             timeout_o;
    logic [c_w-1:0]   cycle_cnt_o;
    logic [c_w-1:0]   latency_o;
    logic [c_n-2:0]   tok_o;

    pipe_commit_tracker #(
        .NUM_STAGES (c_n),
        .CNT_W      (c_w),
        .CNT_LIMIT  (c_lim),
        .END_WINDOW (c_ew)
    ) u_dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .issue_i     (issue_i),
        .valid_s1_i  (valid_s1_i),
        .stall_i     (stall_i),
        .flush_i     (flush_i),
        .start_o     (start_o),
        .started_o   (started_o),
        .commit_o    (commit_o),
        .ended_o     (ended_o),
        .ended2_o    (ended2_o),
        .timeout_o   (timeout_o),
        .cycle_cnt_o (cycle_cnt_o),
        .latency_o   (latency_o),
        .tok_o       (tok_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: observed %0d required %0d at t=%0t", tag, obs, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: phase 0/1/2 = idle/start/started, token tracked as
    // its stage number (0 = no token), counters as plain integers.
    // ------------------------------------------------------------------
    int m_phase, m_cnt, m_pos, m_lat;
    bit m_commit, m_ended, m_ended2;

    task automatic model_reset();
        m_phase = 0; m_cnt = 0; m_pos = 0; m_lat = 0;
        m_commit = 0; m_ended = 0; m_ended2 = 0;
    endtask

    task automatic model_step();
        int n_pos;
        bit n_commit, st, sd, old_ended;
        st = (m_phase == 1);
        sd = (m_phase == 2);
        old_ended = m_ended;
        if (flush_i) begin
            n_pos    = 0;
            n_commit = 0;
        end else begin
            n_commit = (m_pos == c_n) && !stall_i[c_n-1];
            n_pos    = m_pos;
            // An advancing stage hands its token downstream; it is lost
            // if the downstream stage is stalled and therefore not loading.
            if (m_pos >= 2 && !stall_i[m_pos-1]) begin
                if (m_pos < c_n && !stall_i[m_pos]) n_pos = m_pos + 1;
                else                                n_pos = 0;
            end
            if (st && valid_s1_i && !stall_i[0] && !stall_i[1]) n_pos = 2;
        end
        if (m_commit && sd && !old_ended && m_cnt <= c_ew) begin
            m_ended = 1;
            m_lat   = m_cnt;
        end
        if (m_commit && sd && old_ended && !m_ended2) m_ended2 = 1;
        if ((st || sd) && m_cnt < c_lim) m_cnt++;
        if (m_phase == 0 && issue_i) m_phase = 1;
        else if (m_phase == 1)       m_phase = 2;
        m_pos    = n_pos;
        m_commit = n_commit;
    endtask

    task automatic compare();
        logic [c_n-2:0] e_tok;
        e_tok = '0;
        if (m_pos >= 2) e_tok[m_pos-2] = 1'b1;
        chk_eq("start",   start_o,     m_phase == 1);
        chk_eq("started", started_o,   m_phase == 2);
        chk_eq("commit",  commit_o,    m_commit);
        chk_eq("ended",   ended_o,     m_ended);
        chk_eq("ended2",  ended2_o,    m_ended2);
        chk_eq("timeout", timeout_o,   (m_phase == 2) && !m_ended && m_cnt > c_ew);
        chk_eq("cnt",     cycle_cnt_o, m_cnt);
        chk_eq("latency", latency_o,   m_lat);
        chk_eq("tok",     tok_o,       e_tok);
    endtask

    task automatic step();
        @(posedge clk);
        if (rst_n) model_step();
        @(negedge clk);
        compare();
    endtask

    // mode 0: clean run; mode 1: stage-3 stall on the token; mode 2: random
    task automatic drive(input int mode, input int c, input int stall_pct, input int flush_pct);
        if (mode == 2) begin
            issue_i    = ($urandom_range(0, 99) < 20);
            valid_s1_i = ($urandom_range(0, 1) == 1);
            for (int k = 0; k < c_n; k++) stall_i[k] = ($urandom_range(0, 99) < stall_pct);
            flush_i    = ($urandom_range(0, 99) < flush_pct);
        end else begin
            issue_i    = (c == 0);
            valid_s1_i = 1'b1;
            stall_i    = '0;
            if (mode == 1 && c >= 3 && c <= 5) stall_i[2] = 1'b1;
            flush_i    = 1'b0;
        end
    endtask

    task automatic run_trial(input int mode, input int cycles, input int stall_pct,
                             input int flush_pct, input int rst_at);
        // Reset with issue held high: it must not take effect during reset
        rst_n      = 1'b0;
        issue_i    = 1'b1;
        valid_s1_i = 1'b1;
        stall_i    = '0;
        flush_i    = 1'b0;
        model_reset();
        #1 compare();
        @(posedge clk);
        @(negedge clk);
        compare();
        for (int c = 0; c < cycles; c++) begin
            rst_n = 1'b1;
            drive(mode, c, stall_pct, flush_pct);
            if (c == rst_at) begin
                // Asynchronous reset between edges: outputs clear at once
                #2 rst_n = 1'b0;
                model_reset();
                #1 compare();
                @(posedge clk);
                @(negedge clk);
                compare();
            end else begin
                step();
            end
        end
    endtask

    initial begin
        rst_n      = 1'b0;
        issue_i    = 1'b0;
        valid_s1_i = 1'b0;
        stall_i    = '0;
        flush_i    = 1'b0;
        model_reset();
        @(negedge clk);

        // Clean run: commit in cycle 5, latency 4
        run_trial(0, 160, 0, 0, -1);
        chk_eq("clean_latency", latency_o, 4);
        chk_eq("clean_ended",   ended_o,   1);
        chk_eq("clean_cnt_sat", cycle_cnt_o, c_lim);

        // Token stalled three cycles in stage 3: latency 7
        run_trial(1, 80, 0, 0, -1);
        chk_eq("stall_latency", latency_o, 7);
        chk_eq("stall_ended",   ended_o,   1);

        // Randomized traffic across stall/flush densities, some with reset
        for (int t = 0; t < 24; t++) begin
            int sp, fp, ra;
            case (t % 4)
                0:       sp = 0;
                1:       sp = 10;
                2:       sp = 30;
                default: sp = 60;
            endcase
            fp = ((t % 3) == 0) ? 0 : 4;
            ra = ((t % 5) == 2) ? int'($urandom_range(3, 40)) : -1;
            run_trial(2, 170, sp, fp, ra);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_pipe_commit_tracker
`default_nettype wire
